// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        SIGN    = 2'd3
    } div_state_t;

    localparam int unsigned DIV_ITERS     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/add_32.sv
// 32-bit adder built from 4-bit carry-lookahead groups with group-level carry ripple.
module add_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int unsigned k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k]
                       | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
        end
    end

    assign o_sum  = w_p ^ w_c[31:0];
    assign o_cout = w_c[32];

endmodule

// File: rtl/div_32_seq.sv
// Sequential signed 32-bit non-restoring divider feeding the shared add_32.
// Quotient goes to ZLO, remainder to ZHI; start/busy/done handshake to control.
module div_32_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    div_state_t  r_state;
    logic [31:0] r_q;
    logic [32:0] r_r;
    logic [32:0] r_d;
    logic [5:0]  r_cnt;
    logic        r_sq;
    logic        r_sr;
    logic        r_zpend;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_dbz;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_cin;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_sub;
    logic [32:0] w_rs;
    logic [32:0] w_dop;
    logic [32:0] w_iter_r;
    logic [32:0] w_corr_r;
    logic [31:0] w_babs;
    logic [31:0] w_rneg;

    assign w_sub    = ~r_r[32];
    assign w_rs     = {r_r[31:0], r_q[31]};
    assign w_dop    = w_sub ? ~r_d : r_d;
    assign w_iter_r = {w_rs[32] ^ w_dop[32] ^ w_cout, w_sum};
    assign w_corr_r = {r_r[32] ^ r_d[32] ^ w_cout, w_sum};
    assign w_babs   = divisor[31] ? (~divisor + 32'd1) : divisor;
    assign w_rneg   = ~r_r[31:0] + 32'd1;

    // The adder is idle in IDLE, so it takes |dividend| there; SIGN negates Q.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            IDLE: begin
                w_add_a   = ~dividend;
                w_add_cin = 1'b1;
            end
            ITER: begin
                w_add_a   = w_rs[31:0];
                w_add_b   = w_dop[31:0];
                w_add_cin = w_sub;
            end
            CORRECT: begin
                w_add_a   = r_r[31:0];
                w_add_b   = r_d[31:0];
            end
            SIGN: begin
                w_add_a   = ~r_q;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    add_32 u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_sq        <= 1'b0;
            r_sr        <= 1'b0;
            r_zpend     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Divide-by-zero spends one cycle pending so done lands one edge after start.
                    if (r_zpend) begin
                        r_zpend     <= 1'b0;
                        r_quotient  <= DIV_BY_ZERO_Q;
                        r_remainder <= r_q;
                        r_dbz       <= 1'b1;
                        r_done      <= 1'b1;
                    end else if (start) begin
                        r_dbz <= 1'b0;
                        r_cnt <= '0;
                        r_r   <= '0;
                        r_sq  <= dividend[31] ^ divisor[31];
                        r_sr  <= dividend[31];
                        if (divisor == '0) begin
                            r_q     <= dividend;
                            r_zpend <= 1'b1;
                        end else begin
                            r_q     <= dividend[31] ? w_sum : dividend;
                            r_d     <= {1'b0, w_babs};
                            r_busy  <= 1'b1;
                            r_state <= ITER;
                        end
                    end
                end
                ITER: begin
                    r_r   <= w_iter_r;
                    r_q   <= {r_q[30:0], ~w_iter_r[32]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(DIV_ITERS - 1)) begin
                        r_state <= CORRECT;
                    end
                end
                CORRECT: begin
                    if (r_r[32]) begin
                        r_r <= w_corr_r;
                    end
                    r_state <= SIGN;
                end
                SIGN: begin
                    r_quotient  <= r_sq ? w_sum : r_q;
                    r_remainder <= r_sr ? w_rneg : r_r[31:0];
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_32_seq.sv
// Scoreboard bench for div_32_seq: stimulus pushes expected results, a monitor pops on done.
module tb_div_32_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    div_32_seq dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed truncating division, remainder follows the dividend.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int unsigned e0);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.at = e0 + 1;
        end else begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = a; e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
            e.dbz = 1'b0; e.at = e0 + 34;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit wait_first);
        if (wait_first) @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(b != 32'd0));
        if (b != 32'd0) chk("dbz_cleared_on_start", 32'(div_by_zero), 32'd0);
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!clr && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    chk("done_cycle", cyc, e.at);
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        clr = 1'b0;

        issue(32'd100, 32'd7, 1'b1);
        drain(60);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_quotient", quotient, 32'd14);
        chk("hold_remainder", remainder, 32'd2);

        issue(-32'sd100, 32'd7, 1'b1);  drain(60);
        issue(32'd100, -32'sd7, 1'b1);  drain(60);
        issue(32'd100, 32'd0, 1'b1);
        chk("dbz_busy_low", 32'(busy), 32'd0);
        drain(10);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain(60);
        issue(32'h7FFF_FFFF, 32'd1, 1'b1);         drain(60);

        // Back-to-back: next start presented in the done cycle.
        issue(32'd1000, -32'sd10, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        issue(32'hDEAD_BEEF, 32'd3, 1'b0);
        drain(60);

        // Start while busy must be ignored.
        issue(32'd1000, 32'd3, 1'b1);
        repeat (9) @(negedge clk);
        dividend = 32'd55; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(60);
        repeat (40) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(a, b, 1'b1);
            drain(60);
        end

        // Reset mid-ITER, then a normal division.
        issue(32'd77, 32'd5, 1'b1); drain(60);
        issue(32'd123456, 32'd7, 1'b1);
        repeat (14) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_quotient", quotient, 32'd0);
        chk("clr_remainder", remainder, 32'd0);
        chk("clr_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        @(negedge clk);
        clr = 1'b0;
        issue(32'd9, 32'd4, 1'b1);
        drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
